// File: rtl/mod_counter_pkg.sv
// Shared helpers for mod_counter: terminal-count value and parameter legality.
package mod_counter_pkg;

  // Highest count value before wrapping to zero.
  function automatic int terminal_value(input int max);
    return max - 1;
  endfunction

  // Legal when 2 <= MAX <= 2**WIDTH (WIDTH limited to 1..32).
  function automatic bit params_legal(input int width, input int max);
    longint span;
    if (width < 1 || width > 32) return 1'b0;
    span = longint'(1) << width;
    return (max >= 2) && (longint'(max) <= span);
  endfunction

endpackage : mod_counter_pkg

// File: rtl/mod_counter.sv
// Modulo-MAX up-counter with active-low enable and a terminal-count flag for
// cascading. Optional synchronous load is compiled in with MOD_COUNTER_LOAD_EN.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int MAX   = 53
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_n,
`ifdef MOD_COUNTER_LOAD_EN
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             tc
);

  if (!params_legal(WIDTH, MAX)) begin : g_bad_params
    $fatal(1, "mod_counter: MAX=%0d is illegal for WIDTH=%0d", MAX, WIDTH);
  end

  localparam logic [WIDTH-1:0] TERM = WIDTH'(terminal_value(MAX));

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next count: load (if built in) beats enable; terminal or out-of-range wraps to 0.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    q_d = q_q;
    if (!enable_n) begin
      if (q_q >= TERM) q_d = '0;
      else             q_d = q_q + WIDTH'(1);
    end
`ifdef MOD_COUNTER_LOAD_EN
    if (!load_n) begin
      q_d = (d <= TERM) ? d : '0;
    end
`endif
  end

  // Count register; reset clears it immediately without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!reset_n) q_q <= '0;
    else          q_q <= q_d;
  end

  // Terminal-count decode of the registered value and the live enable.
  always_comb begin
    tc = (q_q == TERM) && !enable_n;
`ifdef MOD_COUNTER_LOAD_EN
    if (!load_n) tc = 1'b0;
`endif
  end

  assign Q = q_q;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: a 6-bit/53 instance and a 3-bit/8 instance
// run side by side against an integer modulo model.
module tb_mod_counter;

  localparam int MAX_A = 53;
  localparam int MAX_B = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable_n = 1'b1;
  logic       load_n = 1'b1;
  logic [5:0] d = '0;
  logic [5:0] q_a;
  logic [2:0] q_b;
  logic       tc_a, tc_b;

  int tests = 0;
  int fails = 0;
  int model_a = 0;
  int model_b = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(6), .MAX(MAX_A)) dut_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable_n (enable_n),
`ifdef MOD_COUNTER_LOAD_EN
    .load_n   (load_n),
    .d        (d),
`endif
    .Q        (q_a),
    .tc       (tc_a)
  );

  mod_counter #(.WIDTH(3), .MAX(MAX_B)) dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable_n (enable_n),
`ifdef MOD_COUNTER_LOAD_EN
    .load_n   (1'b1),
    .d        (3'd0),
`endif
    .Q        (q_b),
    .tc       (tc_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs off-edge, check tc, clock, advance the model, check Q.
  task automatic tick(input logic en_n, input logic ld_n, input int dv);
    bit load_active;
    enable_n = en_n;
    load_n   = ld_n;
    d        = 6'(dv);
`ifdef MOD_COUNTER_LOAD_EN
    load_active = !load_n;
`else
    load_active = 1'b0;
`endif
    #1;
    check("tc_a", tc_a, (!enable_n && !load_active && model_a == MAX_A - 1) ? 1 : 0);
    check("tc_b", tc_b, (!enable_n && model_b == MAX_B - 1) ? 1 : 0);
    @(posedge clk);
    if (load_active)    model_a = (int'(d) < MAX_A) ? int'(d) : 0;
    else if (!enable_n) model_a = (model_a + 1) % MAX_A;
    if (!enable_n)      model_b = (model_b + 1) % MAX_B;
    #1;
    check("q_a", q_a, model_a);
    check("q_b", q_b, model_b);
    check("q_a_range", (q_a < MAX_A) ? 1 : 0, 1);
  endtask

  // Asynchronous reset pulse placed mid-cycle; Q must clear before any clock edge.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_a = 0;
    model_b = 0;
    check("rst_q_a", q_a, 0);
    check("rst_q_b", q_b, 0);
    enable_n = 1'b0;
    #1;
    check("rst_tc_a", tc_a, 0);
    check("rst_tc_b", tc_b, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Power-up reset pulse of 1 ns with counting disabled.
    #1 reset_n = 1'b0;
    #1;
    check("por_q_a", q_a, 0);
    check("por_tc_a", tc_a, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 0);

    // Sixty enabled clocks: one full wrap of the 53 counter plus 0..7.
    for (int i = 0; i < 60; i++) tick(1'b0, 1'b1, 0);
    check("after60_a", q_a, 7);

    // Count to 20, hold for 5 clocks, then resume.
    for (int i = 0; i < 13; i++) tick(1'b0, 1'b1, 0);
    check("at20_a", q_a, 20);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 0);
    check("hold20_a", q_a, 20);
    tick(1'b0, 1'b1, 0);
    check("resume21_a", q_a, 21);

    // Count to 30 then reset asynchronously away from the edge.
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, 0);
    check("at30_a", q_a, 30);
    async_reset();
    tick(1'b0, 1'b1, 0);
    check("post_rst_a", q_a, 1);

`ifdef MOD_COUNTER_LOAD_EN
    // Load in-range value with enable asserted, then three counts wrap to 0.
    tick(1'b0, 1'b0, 50);
    check("load50_a", q_a, 50);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 0);
    check("load50_wrap_a", q_a, 0);
    // Out-of-range load clamps to 0.
    tick(1'b0, 1'b1, 0);
    tick(1'b0, 1'b0, 60);
    check("load60_a", q_a, 0);
`endif

    // Randomized enables (and loads when built in) with occasional async resets.
    for (int i = 0; i < 400; i++) begin
      logic en_r;
      logic ld_r;
      en_r = ($urandom_range(0, 3) == 0);
`ifdef MOD_COUNTER_LOAD_EN
      ld_r = ($urandom_range(0, 9) != 0);
`else
      ld_r = 1'b1;
`endif
      tick(en_r, ld_r, int'($urandom_range(0, 63)));
      if ($urandom_range(0, 49) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mod_counter
